// File: rtl/ct_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ct_pkg
//  Purpose  : Shared definitions for the ct_param counter family: MODE
//             encodings and the legal counter width range.
//  Revision : 1.0  initial release
// ============================================================================
package ct_pkg;

  // MODE encodings
  localparam logic [1:0] CT_WRAP    = 2'b00;
  localparam logic [1:0] CT_RELOAD  = 2'b01;
  localparam logic [1:0] CT_ONESHOT = 2'b10;
  localparam logic [1:0] CT_HOLD    = 2'b11;

  // Legal range for the counter width parameter W
  localparam int CT_W_MIN = 2;
  localparam int CT_W_MAX = 16;

endpackage : ct_pkg
`default_nettype wire

// File: rtl/ct_term.sv
`default_nettype none
// ============================================================================
//  Module   : ct_term
//  Purpose  : Combinational terminal-value detector for ct_param.
//  Ports    : count - current counter value
//             mr    - modulus register
//             mode  - counting mode (ct_pkg encodings)
//             dn    - 1 = counting down
//             term  - 1 when the next enabled edge is a terminal event
//  Revision : 1.0  initial release
// ============================================================================
module ct_term
  import ct_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] mr,
  input  logic [1:0]   mode,
  input  logic         dn,
  output logic         term
);

  always_comb begin
    term = 1'b0;
    if (dn) begin
      term = (count == '0);
    end else begin
      case (mode)
        // In reload mode a count above MR (after a load or after MR was
        // lowered) runs on to all-ones and wraps there, which is also a
        // terminal event.
        CT_RELOAD: term = (count == mr) || (&count);
        default:   term = (&count);
      endcase
    end
  end

endmodule : ct_term
`default_nettype wire

// File: rtl/ct_param.sv
`default_nettype none
// ============================================================================
//  Module   : ct_param
//  Purpose  : Parameterised cascadable up/down counter with parallel load,
//             programmable modulus and wrap / reload / one-shot / hold modes.
//  Ports    : C      - clock, rising edge
//             notR   - asynchronous active-low reset
//             D      - parallel load data
//             notEWR - active-low synchronous load of D
//             M      - modulus value, written to MR while LDM=1
//             LDM    - modulus register write strobe
//             MODE   - 00 wrap, 01 reload, 10 one-shot, 11 hold
//             DN     - 0 up, 1 down
//             E1, E2 - count enables (E2 is the cascade input)
//             OUT    - registered count
//             CR     - registered one-cycle terminal-count pulse
//             DONE   - registered one-shot expired flag
//  Revision : 1.0  initial release
// ============================================================================
module ct_param
  import ct_pkg::*;
#(
  parameter int W       = 4,   // legal range CT_W_MIN..CT_W_MAX
  parameter int RST_VAL = 0
) (
  input  logic         C,
  input  logic         notR,
  input  logic [W-1:0] D,
  input  logic         notEWR,
  input  logic [W-1:0] M,
  input  logic         LDM,
  input  logic [1:0]   MODE,
  input  logic         DN,
  input  logic         E1,
  input  logic         E2,
  output logic [W-1:0] OUT,
  output logic         CR,
  output logic         DONE
);

  localparam logic [W-1:0] c_max     = {W{1'b1}};
  localparam logic [W-1:0] c_one     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] c_rst_val = W'(RST_VAL);

  logic [W-1:0] r_count;
  logic [W-1:0] r_mr;
  logic         r_cr;
  logic         r_done;

  logic [W-1:0] w_count_nxt;
  logic         w_cr_nxt;
  logic         w_done_nxt;
  logic         w_term;
  logic         w_count_en;

  ct_term #(
    .W (W)
  ) u_term (
    .count (r_count),
    .mr    (r_mr),
    .mode  (MODE),
    .dn    (DN),
    .term  (w_term)
  );

  // An expired one-shot freezes the count until a load or reset.
  assign w_count_en = E1 & E2 & (MODE != CT_HOLD) &
                      ~((MODE == CT_ONESHOT) & r_done);

  always_comb begin
    w_count_nxt = r_count;
    w_cr_nxt    = 1'b0;
    w_done_nxt  = r_done;
    if (!notEWR) begin
      w_count_nxt = D;
      w_done_nxt  = 1'b0;
    end else if (w_count_en) begin
      if (w_term) begin
        w_cr_nxt = 1'b1;
        case (MODE)
          CT_ONESHOT: w_done_nxt  = 1'b1;
          CT_RELOAD:  w_count_nxt = DN ? r_mr : '0;
          default:    w_count_nxt = DN ? c_max : '0;
        endcase
      end else begin
        w_count_nxt = DN ? (r_count - c_one) : (r_count + c_one);
      end
    end
  end

  always_ff @(posedge C or negedge notR) begin
    if (!notR) begin
      r_count <= c_rst_val;
      r_cr    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_cr    <= w_cr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // The modulus register is written independently of load/count priority.
  always_ff @(posedge C or negedge notR) begin
    if (!notR) begin
      r_mr <= c_max;
    end else if (LDM) begin
      r_mr <= M;
    end
  end

  assign OUT  = r_count;
  assign CR   = r_cr;
  assign DONE = r_done;

endmodule : ct_param
`default_nettype wire
